sprite_scanline_renderer: RTL
=============================

Name: sprite_scanline_renderer

Overview:
Parametrised next-generation sprite line renderer for the racing/arcade video pipeline. It sits between hvsync_generator-derived strobes (vstart, hsync-as-load, hstart) and a combinational bitmap ROM. It fetches one ROM row per scanline and serialises it to a 1-bit gfx stream. It adds generic bitmap width/height, per-frame horizontal/vertical flip, optional left/right mirroring, a synchronous reset and a frame-done pulse.

Parameters:
BITS_W, 8, bitmap row width in bits (>=2)
ROWS, 16, bitmap height in rows (>=2, need not be a power of 2)
AW, $clog2(ROWS), ROM address width (derived; do not override)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
vstart  in  1  sprite top line reached; arms the renderer
load  in  1  per-line fetch request (hsync)
hstart  in  1  sprite left column reached
hflip  in  1  horizontal flip, latched at vstart
vflip  in  1  vertical flip, latched at vstart
mirror  in  1  mirror mode (2*BITS_W pixels wide), latched at vstart
rom_addr  out  AW  registered row address to the bitmap ROM
rom_bits  in  BITS_W  ROM data (combinational from rom_addr)
gfx  out  1  registered pixel output
in_progress  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when the last pixel of the last row is emitted

Behaviour:
- Reset (sync, any state): state=IDLE; gfx=0, rom_addr=0, done=0, ycount=0, xcount=0, outbits=0, mode latches=0. Reset takes priority over every other event, including mid-DRAW.
- States: IDLE, WAIT_LOAD, SETUP, FETCH, WAIT_HSTART, DRAW.
- IDLE: ycount<=0; if vstart, latch hflip/vflip/mirror and go to WAIT_LOAD.
- WAIT_LOAD: xcount<=0; if load, go to SETUP.
- SETUP: rom_addr <= vflip_l ? ROWS-1-ycount : ycount; go to FETCH.
- FETCH: outbits <= rom_bits; go to WAIT_HSTART.
- WAIT_HSTART: if hstart, go to DRAW.
- DRAW: emit one pixel per clock; xcount increments; line length L = mirror_l ? 2*BITS_W : BITS_W.
- Pixel index j for position i (xcount value):
  - no mirror: j = hflip_l ? BITS_W-1-i : i.
  - mirror, i < BITS_W: j = hflip_l ? BITS_W-1-i : i.
  - mirror, i >= BITS_W: j = hflip_l ? i-BITS_W : 2*BITS_W-1-i.
  - gfx <= outbits[j].
- End of line: on the DRAW cycle with xcount==L-1 (pre-increment), ycount increments. If ycount==ROWS-1 (pre-increment), go to IDLE and assert done for exactly that one cycle (registered with the final gfx). Otherwise go to WAIT_LOAD.
- gfx is 0 in every state except DRAW.
- Latency: the first pixel is on gfx 2 cycles after the cycle in which hstart is sampled high in WAIT_HSTART. Pixels are contiguous, L cycles long.
- Strobes arriving in a state that does not consume them are ignored. This covers vstart outside IDLE, load outside WAIT_LOAD, hstart outside WAIT_HSTART, and load/hstart coinciding. Mode inputs are ignored outside the IDLE->WAIT_LOAD transition.
- xcount width is $clog2(2*BITS_W); ycount width is AW. No wrap relies on power-of-2 sizes: all terminal checks are explicit compares.
- Only one state encoding is legal; unreachable encodings go to IDLE with gfx=0.

Decomposition:
- Shared package sprite_pkg: state localparams (IDLE..DRAW), plus a function pixel_index(i, hflip, mirror, BITS_W).
- One natural sub-module: sprite_pixel_mux (combinational xcount/mode/outbits -> pixel bit). It is unit-testable independently of the FSM.
- The ROM stays outside the block (car_bitmap or a parametrised equivalent).

Test Plan:
- BITS_W=8, ROWS=16, all modes 0, row0=8'b00001100. Stimulus: vstart, load, hstart at cycle T. Required: gfx bits 2,3 (time T+4, T+5) high and all other gfx low; gfx low after T+10; in_progress high.
- Same bitmap, mirror=1. Required: 16-pixel line reading 0011000000001100 in time order; xcount terminal at 15.
- hflip=1, no mirror, row0=8'b00000001. Required: the only high gfx is the 8th pixel (T+9).
- vflip=1 with 16 rows. Required: rom_addr sequence is 15,14,...,0 on successive SETUPs; done pulses once on the final pixel; state then returns to IDLE and ignores further load.
- ROWS=12, BITS_W=5. Run a full frame. Required: exactly 12 lines of 5 pixels; done asserted one cycle; rom_addr never exceeds 11.
- Assert reset during DRAW of line 3. Required: next cycle gfx=0, rom_addr=0, in_progress=0. A following vstart restarts the sprite at row 0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and pixel-index helper for the sprite scanline renderer.
// Pure declarations; no state, no timing.
package sprite_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_LOAD   = 3'd1,
    SETUP       = 3'd2,
    FETCH       = 3'd3,
    WAIT_HSTART = 3'd4,
    DRAW        = 3'd5
  } state_t;

  // Bit of the fetched row shown at line position i; the mirrored half
  // replays the first half in the opposite direction.
  function automatic int pixel_index(input int i, input logic hflip,
                                     input logic mirror, input int bits_w);
    int j;
    if (!mirror || i < bits_w) begin
      j = hflip ? (bits_w - 1 - i) : i;
    end else begin
      j = hflip ? (i - bits_w) : (2 * bits_w - 1 - i);
    end
    return j;
  endfunction

endpackage

// File: rtl/sprite_scanline_renderer_if.sv
// Strobe, mode, ROM and pixel signals between the video timing/ROM side
// (master) and the renderer (slave).
interface sprite_scanline_renderer_if #(
  parameter int BITS_W = 8,
  parameter int AW     = 4
);
  logic              vstart;
  logic              load;
  logic              hstart;
  logic              hflip;
  logic              vflip;
  logic              mirror;
  logic [AW-1:0]     rom_addr;
  logic [BITS_W-1:0] rom_bits;
  logic              gfx;
  logic              in_progress;
  logic              done;

  modport master (
    output vstart, load, hstart, hflip, vflip, mirror, rom_bits,
    input  rom_addr, gfx, in_progress, done
  );

  modport slave (
    input  vstart, load, hstart, hflip, vflip, mirror, rom_bits,
    output rom_addr, gfx, in_progress, done
  );
endinterface

// File: rtl/sprite_pixel_mux.sv
// Selects the bitmap bit for the current line position and mode.
// Combinational; no backpressure.
module sprite_pixel_mux
  import sprite_pkg::*;
#(
  parameter int BITS_W = 8,
  parameter int XW     = $clog2(2 * BITS_W)
) (
  input  logic [XW-1:0]     xcount,
  input  logic              hflip,
  input  logic              mirror,
  input  logic [BITS_W-1:0] outbits,
  output logic              pix
);

  int j;

  always_comb begin
    j   = pixel_index(int'(xcount), hflip, mirror, BITS_W);
    pix = 1'b0;
    for (int k = 0; k < BITS_W; k++) begin
      if (k == j) pix = outbits[k];
    end
  end

endmodule

// File: rtl/sprite_scanline_renderer.sv
// Fetches one bitmap row per scanline and serialises it to a 1-bit gfx stream.
// First pixel on gfx 2 cycles after hstart is taken; unconsumed strobes ignored.
module sprite_scanline_renderer
  import sprite_pkg::*;
#(
  parameter int BITS_W = 8,
  parameter int ROWS   = 16,
  parameter int AW     = $clog2(ROWS)
) (
  input  logic                        clk,
  input  logic                        reset,
  sprite_scanline_renderer_if.slave   bus
);

  localparam int XW = $clog2(2 * BITS_W);
  localparam logic [XW-1:0] X_LAST_N = XW'(BITS_W - 1);
  localparam logic [XW-1:0] X_LAST_M = XW'(2 * BITS_W - 1);
  localparam logic [AW-1:0] Y_LAST   = AW'(ROWS - 1);

  state_t            state, state_nxt;
  logic [XW-1:0]     xcount;
  logic [AW-1:0]     ycount;
  logic [BITS_W-1:0] outbits;
  logic [AW-1:0]     rom_addr;
  logic              hflip_l, vflip_l, mirror_l;
  logic              gfx, done;
  logic              line_end, frame_end;
  logic [XW-1:0]     x_last;
  logic              pix;

  sprite_pixel_mux #(.BITS_W(BITS_W), .XW(XW)) u_mux (
    .xcount (xcount),
    .hflip  (hflip_l),
    .mirror (mirror_l),
    .outbits(outbits),
    .pix    (pix)
  );

  assign x_last = mirror_l ? X_LAST_M : X_LAST_N;

  always_comb begin
    state_nxt = state;
    line_end  = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE:        if (bus.vstart) state_nxt = WAIT_LOAD;
      WAIT_LOAD:   if (bus.load)   state_nxt = SETUP;
      SETUP:       state_nxt = FETCH;
      FETCH:       state_nxt = WAIT_HSTART;
      WAIT_HSTART: if (bus.hstart) state_nxt = DRAW;
      DRAW: begin
        if (xcount == x_last) begin
          line_end = 1'b1;
          if (ycount == Y_LAST) begin
            frame_end = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT_LOAD;
          end
        end
      end
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      gfx      <= 1'b0;
      done     <= 1'b0;
      rom_addr <= '0;
      ycount   <= '0;
      xcount   <= '0;
      outbits  <= '0;
      hflip_l  <= 1'b0;
      vflip_l  <= 1'b0;
      mirror_l <= 1'b0;
    end else begin
      state <= state_nxt;
      gfx   <= (state == DRAW) ? pix : 1'b0;
      done  <= frame_end;
      case (state)
        IDLE: begin
          ycount <= '0;
          if (bus.vstart) begin
            hflip_l  <= bus.hflip;
            vflip_l  <= bus.vflip;
            mirror_l <= bus.mirror;
          end
        end
        WAIT_LOAD: xcount <= '0;
        SETUP:     rom_addr <= vflip_l ? (Y_LAST - ycount) : ycount;
        FETCH:     outbits <= bus.rom_bits;
        DRAW: begin
          xcount <= xcount + 1'b1;
          // Overflow past the last row is harmless: IDLE reloads ycount.
          if (line_end) ycount <= ycount + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_addr    = rom_addr;
  assign bus.gfx         = gfx;
  assign bus.done        = done;
  assign bus.in_progress = (state != IDLE);

endmodule
